// File: rtl/perf_event_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : perf_event_counter_bank
// Description : Runtime-statistics counter bank for the multi-cycle MIPS CPU.
//               Counts NUM_CH one-bit event strobes under a start/stop/clr
//               run-control state machine (IDLE, RUN, STOPPED). Each channel
//               has a live counter and a snapshot shadow. A per-channel mode
//               selects wrap or saturate. Each channel has a sticky overflow
//               flag. A registered, select-based readout feeds the
//               display/debug path.
// Optional    : `define PERF_CYCLE_CNT_EN adds a RUN-cycle counter with its
//               own shadow. The counter always wraps and is readable at
//               rd_sel == NUM_CH.
// Ports       : clk        - clock
//               RST        - synchronous active-high reset
//               ev         - event strobes, bit i increments channel i
//               start      - pulse: begin/resume counting
//               stop       - pulse: stop counting and take snapshot
//               clr        - pulse: zero counters, shadows, flags
//               sat_mode   - per channel, 1 = saturate, 0 = wrap
//               rd_sel     - readout channel select
//               rd_live    - 1 = live counter, 0 = snapshot shadow
//               rd_data    - registered readout (1-cycle latency)
//               ovf        - sticky overflow flag per channel
//               running    - high while in RUN
//               snap_valid - a snapshot exists since last clear/reset
// Revision    : 1.0 - initial release
// ============================================================================
module perf_event_counter_bank #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int SEL_W  = 5
) (
  input  logic              clk,
  input  logic              RST,
  input  logic [NUM_CH-1:0] ev,
  input  logic              start,
  input  logic              stop,
  input  logic              clr,
  input  logic [NUM_CH-1:0] sat_mode,
  input  logic [SEL_W-1:0]  rd_sel,
  input  logic              rd_live,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH-1:0] ovf,
  output logic              running,
  output logic              snap_valid
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_STOPPED = 2'd2
  } state_t;

  state_t r_state;

  logic [CNT_W-1:0]  r_cnt     [NUM_CH];
  logic [CNT_W-1:0]  r_shd     [NUM_CH];
  logic [CNT_W-1:0]  w_cnt_nxt [NUM_CH];
  logic [NUM_CH-1:0] w_ovf_hit;
  logic [CNT_W-1:0]  w_rd;

  assign running = (r_state == ST_RUN);

  // --------------------------------------------------------------------------
  // Run-control state machine. Priority: RST > clr > stop > start.
  // A stop outside RUN leaves the state alone but still snapshots.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      snap_valid <= 1'b0;
    end else if (clr) begin
      r_state    <= ST_IDLE;
      snap_valid <= 1'b0;
    end else if (stop) begin
      snap_valid <= 1'b1;
      if (r_state == ST_RUN) begin
        r_state <= ST_STOPPED;
      end
    end else if (start && (r_state != ST_RUN)) begin
      r_state <= ST_RUN;
    end
  end

  // --------------------------------------------------------------------------
  // Next-count computation. The shadow is loaded from the next value, so the
  // increment on the stop edge is part of the snapshot.
  // --------------------------------------------------------------------------
  always_comb begin
    w_ovf_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if ((r_state == ST_RUN) && ev[i]) begin
        if (&r_cnt[i]) begin
          w_ovf_hit[i] = 1'b1;
          w_cnt_nxt[i] = sat_mode[i] ? r_cnt[i] : '0;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RST || clr) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i] <= '0;
        r_shd[i] <= '0;
      end
      ovf <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
        if (stop) begin
          r_shd[i] <= w_cnt_nxt[i];
        end
      end
      ovf <= ovf | w_ovf_hit;
    end
  end

`ifdef PERF_CYCLE_CNT_EN
  // Cycle counter: counts every RUN edge, always wraps, no overflow flag.
  logic [CNT_W-1:0] r_cyc;
  logic [CNT_W-1:0] r_cyc_shd;
  logic [CNT_W-1:0] w_cyc_nxt;

  assign w_cyc_nxt = (r_state == ST_RUN) ? (r_cyc + CNT_W'(1)) : r_cyc;

  always_ff @(posedge clk) begin
    if (RST || clr) begin
      r_cyc     <= '0;
      r_cyc_shd <= '0;
    end else begin
      r_cyc <= w_cyc_nxt;
      if (stop) begin
        r_cyc_shd <= w_cyc_nxt;
      end
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Readout mux. Out-of-range selects read as zero. The live path shows the
  // counter value before the current edge's increment.
  // --------------------------------------------------------------------------
  always_comb begin
    w_rd = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        w_rd = rd_live ? r_cnt[i] : r_shd[i];
      end
    end
`ifdef PERF_CYCLE_CNT_EN
    if (rd_sel == SEL_W'(NUM_CH)) begin
      w_rd = rd_live ? r_cyc : r_cyc_shd;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      rd_data <= '0;
    end else begin
      rd_data <= w_rd;
    end
  end

endmodule
`default_nettype wire

// File: doc/perf_event_counter_bank.md
Name: perf_event_counter_bank

Overview:
- Parametrised runtime-statistics block for the multi-cycle MIPS CPU.
- Counts NUM_CH independent one-bit event strobes, for example:
  - unconditional branch
  - conditional branch
  - conditional branch taken
  - memory access
- A start/stop/clear run-control state machine gates counting.
- Supports snapshot shadow registers, per-channel wrap or saturate mode, sticky overflow flags and a registered select-based readout for the display/debug path.

Parameters:
NUM_CH, 4, number of event channels (1..16)
CNT_W, 16, width of every counter and of rd_data (4..32)
SEL_W, 5, width of rd_sel; must satisfy 2**SEL_W > NUM_CH

Ports:
clk  input  1  clock
RST  input  1  reset; synchronous, active-high; clock clk
ev  input  NUM_CH  event strobes, bit i increments channel i by 1 per cycle
start  input  1  pulse: begin/resume counting
stop  input  1  pulse: stop counting and take snapshot
clr  input  1  pulse: zero all counters, shadows, flags
sat_mode  input  NUM_CH  per channel: 1 = saturate, 0 = wrap
rd_sel  input  SEL_W  readout channel select
rd_live  input  1  1 = read live counter, 0 = read snapshot shadow
rd_data  output  CNT_W  registered readout
ovf  output  NUM_CH  sticky overflow flag per channel
running  output  1  high while state is RUN
snap_valid  output  1  high once a snapshot exists since last clear/reset

Behaviour:
- State machine, states IDLE, RUN, STOPPED; encoding is free.
- Reset (RST=1 at a clk edge):
  - state=IDLE.
  - All live counters, shadows, rd_data, ovf, snap_valid = 0; running = 0.
  - Applies mid-run: counts are lost.
- Command priority at an edge: RST > clr > stop > start.
- clr, from any state:
  - Zeros live counters, shadows, ovf and snap_valid.
  - state=IDLE.
  - Events in the clr cycle are not counted.
- start:
  - IDLE or STOPPED -> RUN.
  - Ignored in RUN.
  - Counters are not cleared, so STOPPED -> RUN resumes accumulation.
- stop:
  - RUN -> STOPPED.
  - In STOPPED or IDLE it changes no state, but still copies live counters to shadows and sets snap_valid=1.
- start and stop in the same cycle: stop wins.
- Counting:
  - At an edge where the current state is RUN and no clr/RST is active, each channel with ev[i]=1 increments.
  - This includes the edge at which stop is sampled.
  - The snapshot taken at that edge holds the post-increment value; live and shadow are equal after stop.
- Width/overflow for channel i at all-ones with ev[i]=1:
  - sat_mode[i]=0: wraps to 0 and sets ovf[i].
  - sat_mode[i]=1: holds all-ones and sets ovf[i].
  - ovf is sticky until clr/RST.
- running = (state==RUN), combinational from the state register.
- Readout:
  - rd_data is registered: 1-cycle latency from rd_sel/rd_live.
  - Valid indices are 0..NUM_CH-1. Any other index returns 0, except the cycle-counter index under the optional feature.
  - Reads have no side effects.
  - Reading live during RUN returns the value before the current edge's increment.
- Idle and stopped states hold all counter values indefinitely.

Optional Feature:
- Macro PERF_CYCLE_CNT_EN.
- When defined:
  - Adds a CNT_W-bit cycle counter that increments on every edge where the state is RUN. Same start/stop/clr/RST rules as the event channels.
  - It always wraps and has no ovf bit.
  - It has a shadow copied on stop.
  - Readable at rd_sel==NUM_CH.
- When undefined:
  - No cycle-counter logic exists.
  - rd_sel==NUM_CH returns 0 like any out-of-range index.

Test Plan:
- Reset, then start; drive ev=4'b0101 for 10 cycles; stop; read sel 0..3 with rd_live=0 -> 10, 0, 10, 0 one cycle after each select; snap_valid=1, running=0.
- STOPPED with counts at 10; start; 5 cycles ev=4'b0001; stop -> ch0 live=15, shadow=15.
- CNT_W=4, sat_mode=4'b0010; 17 cycles ev=4'b0011 in RUN:
  - ch0 = 1, ovf[0]=1 (wrap).
  - ch1 = 15, ovf[1]=1 (saturate).
  - ovf stays set until clr.
- start and stop pulsed together from IDLE -> state stays out of RUN; snapshot taken; snap_valid=1. clr with ev=4'b1111 in RUN -> all counters 0, state IDLE, ovf=0.
- RST asserted mid-run after 7 counted cycles -> next cycle all counts, rd_data, ovf and snap_valid are 0 and running=0; rd_sel=NUM_CH+1 -> rd_data=0.
- With PERF_CYCLE_CNT_EN: 20 cycles in RUN, then stop -> rd_sel=NUM_CH reads 20 in both live and shadow. Without the macro the same read returns 0.
